// File: rtl/program_loader.sv
// Host-side loader: parses a UART byte stream (4-byte big-endian word-count
// header + 4*N program bytes) into an input_start/valid/end frame for inst_fetch.
module program_loader #(
   parameter int INST_MEM_WIDTH = 2,
   parameter int END_GAP        = 2
) (
   input  logic       CLK,
   input  logic       reset,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   output logic       input_start,
   output logic [7:0] input_data,
   output logic       input_valid,
   output logic       input_end,
   output logic       busy,
   output logic       done,
   output logic       error
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HDR  = 2'd1;
   localparam logic [1:0] S_DATA = 2'd2;
   localparam logic [1:0] S_GAP  = 2'd3;

   localparam int CW   = INST_MEM_WIDTH + 3;
   localparam int MAXW = 2 ** INST_MEM_WIDTH;
   localparam int GW   = $clog2(END_GAP + 1);

   logic [1:0]    state;
   logic [23:0]   hdr;
   logic [1:0]    hdr_cnt;
   logic [CW-1:0] byte_cnt;
   logic [GW-1:0] gap_cnt;
   logic [31:0]   word_cnt;
   logic          hdr_bad;

   // The first three header bytes sit in hdr; the fourth is still on rx_data.
   assign word_cnt = {hdr, rx_data};
   assign hdr_bad  = (word_cnt == 32'd0) || (word_cnt > 32'(MAXW));

   always_ff @(posedge CLK) begin
      if (reset) begin
         state       <= S_IDLE;
         hdr         <= '0;
         hdr_cnt     <= '0;
         byte_cnt    <= '0;
         gap_cnt     <= '0;
         input_start <= 1'b0;
         input_data  <= 8'h00;
         input_valid <= 1'b0;
         input_end   <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
      end else begin
         // NOTE: pulse outputs default low here so each branch only raises them;
         // later non-blocking assignments in the same cycle take precedence.
         input_start <= 1'b0;
         input_valid <= 1'b0;
         input_end   <= 1'b0;
         error       <= 1'b0;

         case (state)
            S_IDLE: begin
               busy <= 1'b0;
               if (rx_valid) begin
                  hdr     <= {16'h0000, rx_data};
                  hdr_cnt <= 2'd1;
                  done    <= 1'b0;
                  state   <= S_HDR;
               end
            end

            S_HDR: begin
               if (rx_valid) begin
                  hdr     <= {hdr[15:0], rx_data};
                  hdr_cnt <= hdr_cnt + 2'd1;
                  if (hdr_cnt == 2'd3) begin
                     if (hdr_bad) begin
                        error <= 1'b1;
                        state <= S_IDLE;
                     end else begin
                        input_start <= 1'b1;
                        busy        <= 1'b1;
                        byte_cnt    <= {word_cnt[INST_MEM_WIDTH:0], 2'b00};
                        state       <= S_DATA;
                     end
                  end
               end
            end

            S_DATA: begin
               if (rx_valid) begin
                  input_valid <= 1'b1;
                  input_data  <= rx_data;
                  byte_cnt    <= byte_cnt - CW'(1);
                  if (byte_cnt == CW'(1)) begin
                     gap_cnt <= GW'(END_GAP);
                     state   <= S_GAP;
                  end
               end
            end

            S_GAP: begin
               // Bytes arriving here are deliberately ignored.
               if (gap_cnt == GW'(1)) begin
                  input_end <= 1'b1;
                  done      <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  gap_cnt <= gap_cnt - GW'(1);
               end
            end

            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: a negedge monitor logs output events by
// cycle number; each scenario task compares those logs with hand-derived cycles.
module tb_program_loader;

   logic       CLK = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] rx_data = 8'h00;
   logic       rx_valid = 1'b0;
   logic       input_start, input_valid, input_end, busy, done, error;
   logic [7:0] input_data;

   program_loader #(.INST_MEM_WIDTH(2), .END_GAP(2)) dut (
      .CLK(CLK), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .input_start(input_start), .input_data(input_data), .input_valid(input_valid),
      .input_end(input_end), .busy(busy), .done(done), .error(error)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int       n_checks = 0;
   int       n_fail   = 0;
   int       v_cyc[$];
   logic [7:0] v_dat[$];
   int       start_cyc[$];
   int       end_cyc[$];
   int       err_cyc[$];
   int       excl_bad = 0;
   int       busy_bad = 0;
   int       rx_cyc[$];

   // Output events are logged with the cycle in which they are visible.
   always @(negedge CLK) begin
      if (input_valid) begin v_cyc.push_back(cyc); v_dat.push_back(input_data); end
      if (input_start) start_cyc.push_back(cyc);
      if (input_end)   end_cyc.push_back(cyc);
      if (error)       err_cyc.push_back(cyc);
      if (int'(input_start) + int'(input_valid) + int'(input_end) + int'(error) > 1) excl_bad++;
      if ((input_start || input_end) && !busy) busy_bad++;
   end

   task automatic clear_logs();
      v_cyc.delete(); v_dat.delete(); start_cyc.delete(); end_cyc.delete();
      err_cyc.delete(); rx_cyc.delete(); excl_bad = 0; busy_bad = 0;
   endtask

   // One call = one cycle of input; a byte driven in cycle c is accepted at the
   // end of c, so its output is expected in cycle c+1.
   task automatic drive_cycle(input logic v, input logic [7:0] b);
      @(negedge CLK);
      rx_valid = v;
      rx_data  = b;
      if (v) rx_cyc.push_back(cyc);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive_cycle(1'b0, 8'h00);
   endtask

   task automatic send_header(input logic [31:0] n, output int h4);
      for (int i = 3; i >= 0; i--) drive_cycle(1'b1, n[i*8 +: 8]);
      h4 = rx_cyc[rx_cyc.size()-1];
   endtask

   task automatic expect_int(input string name, input int act, input int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle(3);
      n_checks++;
      if ({input_start, input_valid, input_end, busy, done, error, input_data} !== 14'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b expected all zero",
                  {input_start, input_valid, input_end, busy, done, error, input_data});
      end
      @(negedge CLK);
      reset = 1'b0;
   endtask

   task automatic test_basic_load();
      int h4;
      logic [7:0] bytes [4];
      bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      clear_logs();
      send_header(32'd1, h4);
      idle(2);
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, bytes[i]);
         idle(2);
      end
      idle(6);
      expect_int("basic_start_count", start_cyc.size(), 1);
      if (start_cyc.size() == 1) expect_int("basic_start_cycle", start_cyc[0], h4 + 1);
      expect_int("basic_valid_count", v_cyc.size(), 4);
      if (v_cyc.size() == 4) begin
         for (int i = 0; i < 4; i++) begin
            expect_int($sformatf("basic_valid_cycle%0d", i), v_cyc[i], rx_cyc[4+i] + 1);
            expect_int($sformatf("basic_valid_data%0d", i), int'(v_dat[i]), int'(bytes[i]));
         end
      end
      expect_int("basic_end_count", end_cyc.size(), 1);
      if (end_cyc.size() == 1) expect_int("basic_end_cycle", end_cyc[0], rx_cyc[7] + 3);
      expect_int("basic_done", int'(done), 1);
      expect_int("basic_busy_after", int'(busy), 0);
      expect_int("basic_busy_frame", busy_bad, 0);
      expect_int("basic_exclusive", excl_bad, 0);
   endtask

   task automatic test_zero_header();
      int h4, h4b;
      clear_logs();
      send_header(32'd0, h4);
      idle(3);
      expect_int("zero_err_count", err_cyc.size(), 1);
      if (err_cyc.size() == 1) expect_int("zero_err_cycle", err_cyc[0], h4 + 1);
      expect_int("zero_no_start", start_cyc.size(), 0);
      send_header(32'd1, h4b);
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(8'h10 + i));
      idle(6);
      expect_int("zero_then_start", start_cyc.size(), 1);
      expect_int("zero_then_valids", v_cyc.size(), 4);
      expect_int("zero_then_end", end_cyc.size(), 1);
      expect_int("zero_err_total", err_cyc.size(), 1);
   endtask

   task automatic test_back_to_back();
      int h4;
      clear_logs();
      send_header(32'd5, h4);
      idle(3);
      expect_int("over_err_count", err_cyc.size(), 1);
      if (err_cyc.size() == 1) expect_int("over_err_cycle", err_cyc[0], h4 + 1);
      expect_int("over_no_start", start_cyc.size(), 0);
      clear_logs();
      send_header(32'd4, h4);
      for (int i = 0; i < 16; i++) drive_cycle(1'b1, 8'(8'hC0 + i));
      idle(6);
      expect_int("b2b_start_cycle", start_cyc.size() == 1 ? start_cyc[0] : -1, h4 + 1);
      expect_int("b2b_valid_count", v_cyc.size(), 16);
      if (v_cyc.size() == 16) begin
         for (int i = 0; i < 16; i++) begin
            expect_int($sformatf("b2b_valid_cycle%0d", i), v_cyc[i], h4 + 2 + i);
            expect_int($sformatf("b2b_valid_data%0d", i), int'(v_dat[i]), 8'hC0 + i);
         end
         expect_int("b2b_end_cycle", end_cyc.size() == 1 ? end_cyc[0] : -1, v_cyc[15] + 2);
      end
      expect_int("b2b_exclusive", excl_bad, 0);
   endtask

   task automatic test_byte_at_start();
      int h4;
      clear_logs();
      send_header(32'd1, h4);
      drive_cycle(1'b1, 8'h5A);
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 8'(8'h61 + i));
      idle(6);
      expect_int("start_byte_rx_cycle", rx_cyc[4], h4 + 1);
      expect_int("start_byte_valid_count", v_cyc.size(), 4);
      if (v_cyc.size() >= 1) begin
         expect_int("start_byte_valid_cycle", v_cyc[0], h4 + 2);
         expect_int("start_byte_data", int'(v_dat[0]), 8'h5A);
      end
      expect_int("start_byte_end_cycle", end_cyc.size() == 1 ? end_cyc[0] : -1, rx_cyc[7] + 3);
   endtask

   task automatic test_gap_drop();
      int h4, h4b;
      clear_logs();
      send_header(32'd1, h4);
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(8'h20 + i));
      drive_cycle(1'b1, 8'h00);   // arrives in the gap, must be ignored
      idle(5);
      expect_int("gap_valid_count", v_cyc.size(), 4);
      expect_int("gap_end_cycle", end_cyc.size() == 1 ? end_cyc[0] : -1, rx_cyc[7] + 3);
      expect_int("gap_done_set", int'(done), 1);
      clear_logs();
      drive_cycle(1'b1, 8'h00);
      drive_cycle(1'b0, 8'h00);
      expect_int("gap_done_cleared", int'(done), 0);
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, i == 2 ? 8'h01 : 8'h00);
      h4b = rx_cyc[3];
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(8'h30 + i));
      idle(6);
      expect_int("gap_no_error", err_cyc.size(), 0);
      expect_int("gap_next_start", start_cyc.size() == 1 ? start_cyc[0] : -1, h4b + 1);
      expect_int("gap_next_valids", v_cyc.size(), 4);
   endtask

   task automatic test_reset_mid_load();
      int h4;
      clear_logs();
      send_header(32'd2, h4);
      for (int i = 0; i < 6; i++) drive_cycle(1'b1, 8'(8'h40 + i));
      @(negedge CLK);
      rx_valid = 1'b0;
      reset    = 1'b1;
      @(negedge CLK);
      n_checks++;
      if ({input_start, input_valid, input_end, busy, done, error, input_data} !== 14'h0) begin
         n_fail++;
         $display("FAIL midreset_outputs: got %b expected all zero",
                  {input_start, input_valid, input_end, busy, done, error, input_data});
      end
      reset = 1'b0;
      idle(6);
      expect_int("midreset_valids", v_cyc.size(), 6);
      expect_int("midreset_no_end", end_cyc.size(), 0);
      clear_logs();
      send_header(32'd1, h4);
      for (int i = 0; i < 4; i++) drive_cycle(1'b1, 8'(8'h50 + i));
      idle(6);
      expect_int("midreset_reload_start", start_cyc.size() == 1 ? start_cyc[0] : -1, h4 + 1);
      expect_int("midreset_reload_valids", v_cyc.size(), 4);
      if (v_cyc.size() == 4) expect_int("midreset_reload_last", int'(v_dat[3]), 8'h53);
      expect_int("midreset_reload_end", end_cyc.size() == 1 ? end_cyc[0] : -1, rx_cyc[7] + 3);
      expect_int("midreset_done", int'(done), 1);
   endtask

   initial begin
      test_reset();
      test_basic_load();
      test_zero_header();
      test_back_to_back();
      test_byte_at_start();
      test_gap_drop();
      test_reset_mid_load();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
